hotlist_drain: RTL
==================

// Module: hotlist_drain
// PURPOSE
// Consumer end of the hotlist pop/handshake interface. Pops one hot-page entry at a time from the hotlist,
// drops entries whose count is below a programmable threshold, and converts the page address to a byte address.
// Surviving entries go out as migration requests over a valid/ready channel. Sits between the hotlist and the
// page-migration engine; single request outstanding, optional per-migration cooldown, saturating statistics.
// PARAMETERS
// ADDR_SIZE   21  page-address width of a hotlist entry
// CNT_SIZE    12  access-count width of a hotlist entry
// PAGE_SHIFT  12  log2 page size in bytes; byte address = page address << PAGE_SHIFT
// COOL_WIDTH  16  width of cooldown counter / cooldown input
// STAT_WIDTH  16  width of issued/dropped statistic counters
// PORTS
// clk                 in   1                      clock
// rst_n               in   1                      asynchronous active-low reset
// enable              in   1                      permit new pops; in-flight work always completes
// threshold           in   CNT_SIZE               minimum count to migrate (sampled when entry accepted)
// cooldown            in   COOL_WIDTH             idle cycles enforced after each mig_done
// query_en            out  1                      pop request to hotlist
// query_ready         in   1                      hotlist non-empty and output slot free
// mig_addr_cnt_ready  in   1                      hotlist output entry valid
// mig_addr_cnt        in   ADDR_SIZE+CNT_SIZE     {addr, cnt} from hotlist
// mig_addr_cnt_en     out  1                      entry accept (handshake with mig_addr_cnt_ready)
// mig_req_valid       out  1                      migration request valid
// mig_req_ready       in   1                      migration engine accepts request
// mig_req_addr        out  ADDR_SIZE+PAGE_SHIFT   byte address of page to migrate
// mig_req_cnt         out  CNT_SIZE               access count of that page
// mig_done            in   1                      one-cycle pulse: outstanding migration finished
// busy                out  1                      state != IDLE or cooldown counter nonzero
// issued_cnt          out  STAT_WIDTH             requests completed (mig_done seen), saturating
// dropped_cnt         out  STAT_WIDTH             entries dropped below threshold, saturating
// BEHAVIOUR
// Reset (async, rst_n=0): state=IDLE, cool_ctr=0, latched addr/cnt=0, issued_cnt=dropped_cnt=0; all outputs 0.
// FSM states: IDLE, WAIT_ENTRY, ISSUE, WAIT_DONE.
// IDLE: query_en = enable && (cool_ctr==0), combinational from state/regs. If query_en && query_ready
//   (pop), next state is WAIT_ENTRY. cool_ctr decrements by 1 each cycle while nonzero.
// WAIT_ENTRY: mig_addr_cnt_en=1 (held). If mig_addr_cnt_ready, latch addr/cnt in the same cycle, then:
//   - cnt >= threshold: next state ISSUE.
//   - otherwise: dropped_cnt+1 (saturating), next state IDLE.
//   - The hotlist presents the entry 1 cycle after the pop, so at least 1 cycle is spent here.
// ISSUE: mig_req_valid=1; mig_req_addr={addr,PAGE_SHIFT'b0}; mig_req_cnt=cnt. Outputs are stable while valid
//   && !ready. If mig_req_ready, next state WAIT_DONE.
// WAIT_DONE: if mig_done, issued_cnt+1 (saturating), cool_ctr<=cooldown, next state IDLE.
// mig_done outside WAIT_DONE is ignored; it is not counted.
// mig_req_addr and mig_req_cnt hold their last values outside ISSUE; only mig_req_valid qualifies them.
// Never more than one entry popped and not yet issued/dropped; never more than one migration outstanding.
// Deasserting enable blocks only the IDLE pop; a current entry still completes through ISSUE/WAIT_DONE.
// cooldown=0: the next pop may occur in the cycle after mig_done. threshold=0: no entry is dropped.
// Counters saturate at all-ones and do not wrap.
// Best-case latency pop->mig_req_valid: 2 cycles (pop cycle, entry-accept cycle, then ISSUE).
// Reset mid-operation: returns to IDLE immediately; any latched entry is discarded; no request is re-issued.
// TESTING
// Reset: hold rst_n=0 with query_ready=1, enable=1 -> query_en=0, mig_req_valid=0, both counters 0.
// Basic flow: thr=10, cd=0; push addr=0x1ABCD cnt=20; ready=1 -> query_en; 2 cycles after pop,
//   mig_req_valid=1, mig_req_addr=0x1ABCD000, cnt=20; pulse done -> issued_cnt=1, next pop next cycle.
// Drop: thr=10, entry cnt=9 -> mig_addr_cnt_en handshake, no mig_req_valid, dropped_cnt=1, returns to IDLE;
//   a second entry with cnt=10 is issued.
// Backpressure: hold mig_req_ready=0 for 5 cycles -> valid/addr/cnt stable, no further query_en.
//   Spurious mig_done during ISSUE does not change issued_cnt.
// Cooldown/enable: cd=4 -> no query_en for 4 cycles after mig_done. Deassert enable during WAIT_DONE ->
//   completes, then query_en stays 0 until enable=1.
// Saturation and async reset: STAT_WIDTH=4, 20 drops -> dropped_cnt=15. Assert rst_n=0 in ISSUE between
//   edges -> mig_req_valid drops immediately; after release, idle until the next pop.

Source files
------------

// File: rtl/hotlist_drain.sv
// ---------------------------------------------------------------------------
// hotlist_drain
//
// Consumer end of the hotlist pop/handshake interface. Pops one hot-page
// entry at a time, drops entries whose access count is below a programmable
// threshold, and turns surviving page addresses into byte-address migration
// requests on a valid/ready channel. Only one entry is ever in flight, and
// only one migration is ever outstanding. An optional cooldown holds off the
// next pop after each completed migration. Issued and dropped statistics
// saturate at all-ones.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              permit new pops (in-flight work always completes)
//   threshold           minimum count to migrate, sampled at entry accept
//   cooldown            idle cycles enforced after each mig_done
//   query_en            pop request to the hotlist
//   query_ready         hotlist non-empty and its output slot free
//   mig_addr_cnt_ready  hotlist output entry valid
//   mig_addr_cnt        {page addr, count} from the hotlist
//   mig_addr_cnt_en     entry accept strobe
//   mig_req_valid       migration request valid
//   mig_req_ready       migration engine accepts the request
//   mig_req_addr        byte address of the page to migrate
//   mig_req_cnt         access count of that page
//   mig_done            one-cycle pulse: outstanding migration finished
//   busy                not idle, or cooldown still running
//   issued_cnt          completed migrations (saturating)
//   dropped_cnt         entries dropped below threshold (saturating)
// ---------------------------------------------------------------------------
module hotlist_drain #(
  parameter int ADDR_SIZE  = 21,
  parameter int CNT_SIZE   = 12,
  parameter int PAGE_SHIFT = 12,
  parameter int COOL_WIDTH = 16,
  parameter int STAT_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic [CNT_SIZE-1:0]             threshold,
  input  logic [COOL_WIDTH-1:0]           cooldown,
  output logic                            query_en,
  input  logic                            query_ready,
  input  logic                            mig_addr_cnt_ready,
  input  logic [ADDR_SIZE+CNT_SIZE-1:0]   mig_addr_cnt,
  output logic                            mig_addr_cnt_en,
  output logic                            mig_req_valid,
  input  logic                            mig_req_ready,
  output logic [ADDR_SIZE+PAGE_SHIFT-1:0] mig_req_addr,
  output logic [CNT_SIZE-1:0]             mig_req_cnt,
  input  logic                            mig_done,
  output logic                            busy,
  output logic [STAT_WIDTH-1:0]           issued_cnt,
  output logic [STAT_WIDTH-1:0]           dropped_cnt
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_ENTRY = 2'd1;
  localparam logic [1:0] ST_ISSUE      = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE  = 2'd3;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] val);
    if (&val) begin
      return val;
    end else begin
      return val + {{(STAT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

  logic [1:0]            state_r;
  logic [1:0]            state_nxt_s;
  logic                  armed_r;
  logic [COOL_WIDTH-1:0] cool_r;
  logic [ADDR_SIZE-1:0]  addr_r;
  logic [CNT_SIZE-1:0]   cnt_r;
  logic [STAT_WIDTH-1:0] issued_r;
  logic [STAT_WIDTH-1:0] dropped_r;

  logic [ADDR_SIZE-1:0]  entry_addr_s;
  logic [CNT_SIZE-1:0]   entry_cnt_s;
  logic                  query_en_s;
  logic                  pop_s;
  logic                  accept_s;
  logic                  keep_s;
  logic                  req_fire_s;
  logic                  done_s;
  logic                  cool_busy_s;

  assign entry_addr_s = mig_addr_cnt[ADDR_SIZE+CNT_SIZE-1:CNT_SIZE];
  assign entry_cnt_s  = mig_addr_cnt[CNT_SIZE-1:0];
  assign cool_busy_s  = |cool_r;

  // armed_r keeps query_en low while reset is held (IDLE would otherwise
  // pop straight away); it rises on the first clock after reset release.
  assign query_en_s = armed_r && (state_r == ST_IDLE) && enable && !cool_busy_s;
  assign pop_s      = query_en_s && query_ready;
  assign accept_s   = (state_r == ST_WAIT_ENTRY) && mig_addr_cnt_ready;
  // Threshold is compared against the entry as it arrives, so a threshold
  // change only affects entries accepted afterwards.
  assign keep_s     = (entry_cnt_s >= threshold);
  assign req_fire_s = (state_r == ST_ISSUE) && mig_req_ready;
  // mig_done is only meaningful while a migration is outstanding.
  assign done_s     = (state_r == ST_WAIT_DONE) && mig_done;

  // Next-state decode for the pop / accept / issue / wait-done sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) begin
          state_nxt_s = ST_WAIT_ENTRY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT_ENTRY: begin
        if (accept_s && keep_s) begin
          state_nxt_s = ST_ISSUE;
        end else if (accept_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_ENTRY;
        end
      end
      ST_ISSUE: begin
        if (req_fire_s) begin
          state_nxt_s = ST_WAIT_DONE;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_WAIT_DONE: begin
        if (done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register and post-reset arming flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      armed_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      armed_r <= 1'b1;
    end
  end

  // Cooldown counter: loaded on a completed migration, then counts down to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cool_r <= {COOL_WIDTH{1'b0}};
    end else if (done_s) begin
      cool_r <= cooldown;
    end else if (cool_busy_s) begin
      cool_r <= cool_r - {{(COOL_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cool_r <= cool_r;
    end
  end

  // Entry latch: captured on accept and held so the request payload stays
  // stable under backpressure and keeps its last value afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= {ADDR_SIZE{1'b0}};
      cnt_r  <= {CNT_SIZE{1'b0}};
    end else if (accept_s) begin
      addr_r <= entry_addr_s;
      cnt_r  <= entry_cnt_s;
    end else begin
      addr_r <= addr_r;
      cnt_r  <= cnt_r;
    end
  end

  // Saturating statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_r  <= {STAT_WIDTH{1'b0}};
      dropped_r <= {STAT_WIDTH{1'b0}};
    end else begin
      if (done_s) begin
        issued_r <= sat_inc(issued_r);
      end else begin
        issued_r <= issued_r;
      end
      if (accept_s && !keep_s) begin
        dropped_r <= sat_inc(dropped_r);
      end else begin
        dropped_r <= dropped_r;
      end
    end
  end

  // Outputs are pure decodes of registers, so an asynchronous reset clears
  // them without waiting for a clock edge.
  assign query_en        = query_en_s;
  assign mig_addr_cnt_en = (state_r == ST_WAIT_ENTRY);
  assign mig_req_valid   = (state_r == ST_ISSUE);
  assign mig_req_addr    = {addr_r, {PAGE_SHIFT{1'b0}}};
  assign mig_req_cnt     = cnt_r;
  assign busy            = (state_r != ST_IDLE) || cool_busy_s;
  assign issued_cnt      = issued_r;
  assign dropped_cnt     = dropped_r;

endmodule
